// File: rtl/intersection_sched_pkg.sv
// Shared definitions for the intersection scheduler: FSM states, light count
// and the round-robin next-light search.
package intersection_sched_pkg;

    localparam int unsigned NUM_LIGHTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALLRED = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } sched_state_t;

    // Returns {found, index}: first eligible light after cur, wrapping 3->0.
    // The current owner itself is checked last, so a lone eligible light repeats.
    function automatic logic [2:0] find_next(input logic [1:0] cur,
                                             input logic [NUM_LIGHTS-1:0] eligible);
        logic [2:0] result;
        logic [1:0] idx;
        result = '0;
        for (int unsigned k = 1; k <= NUM_LIGHTS; k++) begin
            idx = 2'(32'(cur) + k);
            if (!result[2] && eligible[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Loadable phase down-counter; advances only on unheld ticks and never
// decrements below 1, so a phase loaded with N spans exactly N ticks.
module phase_timer #(
    parameter int unsigned TIME_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              tick,
    input  logic              hold,
    output logic [TIME_W-1:0] remain,
    output logic              expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= '0;
        end else if (load) begin
            remain <= load_val;
        end else if (tick && !hold && (remain > TIME_W'(1))) begin
            remain <= remain - 1'b1;
        end
    end

    assign expire = tick && !hold && (remain == TIME_W'(1));

endmodule

// File: rtl/intersection_scheduler.sv
// Four-light round-robin traffic sequencer: GREEN -> YELLOW -> ALL_RED with
// per-light green times. Optional macro SCHED_DEMAND_EN adds req/req_ack demand gating.
module intersection_scheduler
    import intersection_sched_pkg::*;
#(
    parameter int unsigned TIME_W        = 4,
    parameter int unsigned DEFAULT_GREEN = 5,
    parameter int unsigned YELLOW_TICKS  = 3,
    parameter int unsigned ALLRED_TICKS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              run,
    input  logic              pause,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [TIME_W-1:0] cfg_time,
`ifdef SCHED_DEMAND_EN
    input  logic [3:0]        req,
    output logic [3:0]        req_ack,
`endif
    output logic [3:0]        green,
    output logic [3:0]        yellow,
    output logic [1:0]        phase_idx,
    output logic [TIME_W-1:0] remain,
    output logic              busy
);

    localparam logic [TIME_W-1:0] GREEN_RST = TIME_W'(DEFAULT_GREEN);
    localparam logic [TIME_W-1:0] YEL_LEN   = TIME_W'(YELLOW_TICKS);
    localparam logic [TIME_W-1:0] AR_LEN    = TIME_W'(ALLRED_TICKS);

    sched_state_t              state, state_n;
    logic [1:0]                phase_n;
    logic                      load;
    logic [TIME_W-1:0]         load_val;
    logic                      expire;
    logic [TIME_W-1:0]         green_time [NUM_LIGHTS];
    logic [NUM_LIGHTS-1:0]     eligible;
    logic [2:0]                pick;
`ifdef SCHED_DEMAND_EN
    logic [3:0]                ack_n;
`endif

    phase_timer #(.TIME_W(TIME_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .hold     (pause),
        .remain   (remain),
        .expire   (expire)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
            eligible[i] = (green_time[i] != '0);
`ifdef SCHED_DEMAND_EN
            eligible[i] = eligible[i] & req[i];
`endif
        end
    end

    assign pick = find_next(phase_idx, eligible);

    always_comb begin
        state_n  = state;
        phase_n  = phase_idx;
        load     = 1'b0;
        load_val = '0;
`ifdef SCHED_DEMAND_EN
        ack_n    = '0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (run && !pause) begin
                    state_n  = ST_ALLRED;
                    load     = 1'b1;
                    load_val = AR_LEN;
                end
            end
            ST_ALLRED: begin
                if (expire) begin
                    load = 1'b1;
                    if (!run) begin
                        state_n  = ST_IDLE;
                        load_val = '0;
                    end else if (pick[2]) begin
                        state_n  = ST_GREEN;
                        phase_n  = pick[1:0];
                        load_val = green_time[pick[1:0]];
`ifdef SCHED_DEMAND_EN
                        ack_n[pick[1:0]] = 1'b1;
`endif
                    end else begin
                        load_val = AR_LEN;
                    end
                end
            end
            ST_GREEN: begin
                // A run=0 abort cuts green short, but only while not paused.
                if ((!run && !pause) || expire) begin
                    state_n  = ST_YELLOW;
                    load     = 1'b1;
                    load_val = YEL_LEN;
                end
            end
            ST_YELLOW: begin
                if (expire) begin
                    state_n  = ST_ALLRED;
                    load     = 1'b1;
                    load_val = AR_LEN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase_idx <= 2'd3;
            green     <= '0;
            yellow    <= '0;
        end else begin
            state     <= state_n;
            phase_idx <= phase_n;
            green     <= (state_n == ST_GREEN)  ? (4'b0001 << phase_n) : '0;
            yellow    <= (state_n == ST_YELLOW) ? (4'b0001 << phase_n) : '0;
        end
    end

`ifdef SCHED_DEMAND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ack <= '0;
        end else begin
            req_ack <= ack_n;
        end
    end
`endif

    // Green entry reads green_time combinationally, so a same-cycle write lands after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
                green_time[i] <= GREEN_RST;
            end
        end else if (cfg_we) begin
            green_time[cfg_sel] <= cfg_time;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: vector table, directed
// multi-cycle scenarios and randomized traffic against a behavioural model.
module tb_intersection_scheduler;

    localparam int ALLRED = 1;
    localparam int YEL    = 3;
    localparam int M_IDLE = 0, M_ALLRED = 1, M_GREEN = 2, M_YELLOW = 3;

    logic       clk = 1'b0;
    logic       rst_n, tick, run, pause, cfg_we;
    logic [1:0] cfg_sel;
    logic [3:0] cfg_time;
    logic [3:0] green, yellow;
    logic [1:0] phase_idx;
    logic [3:0] remain;
    logic       busy;
`ifdef SCHED_DEMAND_EN
    logic [3:0] req, req_ack;
    int         n_ack;
`endif

    always #5 clk = ~clk;

    intersection_scheduler #(
        .TIME_W(4), .DEFAULT_GREEN(5), .YELLOW_TICKS(3), .ALLRED_TICKS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .pause(pause),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_time(cfg_time),
`ifdef SCHED_DEMAND_EN
        .req(req), .req_ack(req_ack),
`endif
        .green(green), .yellow(yellow), .phase_idx(phase_idx),
        .remain(remain), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, ticks left, light owning the phase, green table.
    int       m_st, m_rem, m_own;
    int       m_gt [4];
    logic [3:0] m_ack;

    task automatic model_reset();
        m_st = M_IDLE; m_rem = 0; m_own = 3; m_ack = '0;
        for (int i = 0; i < 4; i++) m_gt[i] = 5;
    endtask

    task automatic model_edge();
        int nst, nrem, nown, idx;
        bit moved, ends;
        logic [3:0] dem;
        nst = m_st; nrem = m_rem; nown = m_own; moved = 0; m_ack = '0;
        dem = 4'hF;
`ifdef SCHED_DEMAND_EN
        dem = req;
`endif
        ends = tick && !pause && (m_rem == 1);
        if (!pause) begin
            case (m_st)
                M_IDLE: if (run) begin nst = M_ALLRED; nrem = ALLRED; moved = 1; end
                M_ALLRED: if (ends) begin
                    moved = 1;
                    if (!run) begin
                        nst = M_IDLE; nrem = 0;
                    end else begin
                        nrem = ALLRED;
                        for (int k = 1; k <= 4; k++) begin
                            idx = (m_own + k) % 4;
                            if (m_gt[idx] != 0 && dem[idx]) begin
                                nst = M_GREEN; nown = idx; nrem = m_gt[idx];
                                m_ack = 4'b0001 << idx;
                                break;
                            end
                        end
                    end
                end
                M_GREEN: if (!run || ends) begin nst = M_YELLOW; nrem = YEL; moved = 1; end
                default: if (ends) begin nst = M_ALLRED; nrem = ALLRED; moved = 1; end
            endcase
        end
        if (!moved && !pause && tick && m_rem > 1) nrem = m_rem - 1;
        if (cfg_we) m_gt[cfg_sel] = int'(cfg_time);
        m_st = nst; m_rem = nrem; m_own = nown;
    endtask

    task automatic check_model();
        chk("green",  green,  (m_st == M_GREEN)  ? (4'b0001 << m_own) : 4'b0);
        chk("yellow", yellow, (m_st == M_YELLOW) ? (4'b0001 << m_own) : 4'b0);
        chk("phase_idx", phase_idx, m_own);
        chk("remain", remain, m_rem);
        chk("busy",   busy,   m_st != M_IDLE);
`ifdef SCHED_DEMAND_EN
        chk("req_ack", req_ack, m_ack);
`endif
    endtask

    // Observation of green entries and per-light green length in ticks.
    int order[$];
    int cur_dur;
    int last_dur [4];

    task automatic step();
        logic [3:0] pg;
        logic [1:0] pp;
        pg = green; pp = phase_idx;
        if (tick && green != 0) cur_dur++;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        if (green != 0 && pg == 0) begin order.push_back(int'(phase_idx)); cur_dur = 0; end
        if (green == 0 && pg != 0) last_dur[pp] = cur_dur;
`ifdef SCHED_DEMAND_EN
        if (req_ack != 0) n_ack++;
`endif
    endtask

    task automatic tick_once();
        repeat (9) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; tick = 0; run = 0; pause = 0; cfg_we = 0; cfg_sel = 0; cfg_time = 0;
`ifdef SCHED_DEMAND_EN
        req = 4'hF; n_ack = 0;
`endif
        model_reset();
        order.delete(); cur_dur = 0;
        for (int i = 0; i < 4; i++) last_dur[i] = 0;
        #1;
        chk("rst_green", green, 0);
        chk("rst_yellow", yellow, 0);
        chk("rst_phase", phase_idx, 3);
        chk("rst_remain", remain, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_cfg(input int sel, input int t);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_time = 4'(t);
        step();
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic       run, pause, tick;
        logic [3:0] g, y;
        logic [1:0] ph;
        logic [3:0] rem;
        logic       busy;
    } vec_t;

    vec_t tbl [10];
    int   budget;
    bit   seen;
    logic [3:0] ysave;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'd3, 4'd1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 2'd0, 4'd5, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 2'd0, 4'd4, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 4'h1, 4'h0, 2'd0, 4'd4, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 2'd0, 4'd3, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 2'd0, 4'd2, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 2'd0, 4'd1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd0, 4'd1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0};

        rst_n = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run = tbl[i].run; pause = tbl[i].pause; tick = tbl[i].tick;
            step();
            chk($sformatf("vec%0d_green", i), green, tbl[i].g);
            chk($sformatf("vec%0d_yellow", i), yellow, tbl[i].y);
            chk($sformatf("vec%0d_phase", i), phase_idx, tbl[i].ph);
            chk($sformatf("vec%0d_remain", i), remain, tbl[i].rem);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
        end
        tick = 0; pause = 0;

        // Default round robin: 0,1,2,3,0 with 5-tick greens.
        do_reset();
        run = 1;
        budget = 0;
        while (order.size() < 5 && budget < 60) begin tick_once(); budget++; end
        chk("t1_timeout", budget < 60, 1);
        for (int k = 0; k < 5; k++) chk($sformatf("t1_order%0d", k), (k < order.size()) ? order[k] : -1, k % 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t1_dur%0d", k), last_dur[k], 5);

        // Light 1 disabled, light 3 shortened to 2 ticks.
        do_reset();
        write_cfg(1, 0);
        write_cfg(3, 2);
        run = 1; seen = 0; budget = 0;
        while (order.size() < 4 && budget < 60) begin
            tick_once(); budget++;
            if (green[1]) seen = 1;
        end
        chk("t2_timeout", budget < 60, 1);
        chk("t2_light1_never", seen, 0);
        for (int k = 0; k < 4; k++) begin
            int exp_l;
            exp_l = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 3 : 0;
            chk($sformatf("t2_order%0d", k), (k < order.size()) ? order[k] : -1, exp_l);
        end
        chk("t2_dur3", last_dur[3], 2);

        // Abort while light 2 is green with 4 ticks left.
        do_reset();
        run = 1; budget = 0;
        while (!(green == 4'b0100 && remain == 4) && budget < 60) begin tick_once(); budget++; end
        chk("t3_timeout", budget < 60, 1);
        run = 0;
        step();
        chk("t3_yellow", yellow, 4'b0100);
        chk("t3_yrem", remain, 3);
        repeat (3) tick_once();
        chk("t3_allred_g", green | yellow, 0);
        chk("t3_allred_busy", busy, 1);
        tick_once();
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_rem", remain, 0);

        // Pause for 20 ticks mid-yellow.
        do_reset();
        run = 1; budget = 0;
        while (yellow == 0 && budget < 60) begin tick_once(); budget++; end
        chk("t4_timeout", budget < 60, 1);
        tick_once();
        chk("t4_rem_before", remain, 2);
        ysave = yellow;
        pause = 1;
        repeat (20) tick_once();
        chk("t4_rem_frozen", remain, 2);
        chk("t4_y_frozen", yellow, ysave);
        pause = 0;
        tick_once();
        chk("t4_rem_after", remain, 1);
        tick_once();
        chk("t4_y_done", yellow, 0);

        // All lights disabled, then light 3 enabled.
        do_reset();
        for (int i = 0; i < 4; i++) write_cfg(i, 0);
        run = 1; seen = 0;
        repeat (10) begin tick_once(); if (green != 0) seen = 1; end
        chk("t5_no_green", seen, 0);
        chk("t5_busy", busy, 1);
        write_cfg(3, 2);
        tick_once();
        chk("t5_green3", green, 4'b1000);
        chk("t5_rem", remain, 2);
        repeat (2) tick_once();
        chk("t5_yellow3", yellow, 4'b1000);

`ifdef SCHED_DEMAND_EN
        // Demand only on light 3.
        do_reset();
        req = 4'b1000; run = 1;
        repeat (30) tick_once();
        chk("t6_entries", order.size() >= 2, 1);
        for (int k = 0; k < order.size(); k++) chk($sformatf("t6_order%0d", k), order[k], 3);
        chk("t6_acks", n_ack, order.size());
        req = 4'hF;
`endif

        // Asynchronous reset in the middle of a green phase.
        do_reset();
        run = 1; budget = 0;
        while (green == 0 && budget < 60) begin tick_once(); budget++; end
        chk("t7_timeout", budget < 60, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_green", green, 0);
        chk("t7_yellow", yellow, 0);
        chk("t7_remain", remain, 0);
        chk("t7_busy", busy, 0);
        chk("t7_phase", phase_idx, 3);
`ifdef SCHED_DEMAND_EN
        chk("t7_ack", req_ack, 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        run = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) run = ~run;
            tick   = ($urandom_range(0, 3) == 0);
            pause  = ($urandom_range(0, 11) == 0);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_sel  = 2'($urandom_range(0, 3));
            cfg_time = 4'($urandom_range(0, 6));
`ifdef SCHED_DEMAND_EN
            if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
